// File: rtl/window_result_reader.sv
// rtl/window_result_reader.sv - drains window_analysis result FIFO into a valid/ready record stream
//
// Purpose:
//   Watches the window_analysis output FIFO state, issues single-cycle read strobes,
//   captures the record after a fixed read latency and presents its unpacked fields
//   on a valid/ready interface. Flags cycle-number gaps and sticky FIFO overflow, and
//   counts records accepted downstream.
//
// Ports:
//   clk              in   system clock, rising edge
//   rst_in           in   asynchronous reset, active high
//   enable_in        in   1 = start new reads; 0 = finish current record, then idle
//   clear_in         in   sync pulse: clear counter, overflow flag and gap history
//   fifo_state_in    in   [3] full, [2] empty, [1] almost full, [0] almost empty
//   read_data_in     in   FIFO record {cycle, zero_offset, max_amp, max_time}
//   read_enable_out  out  one-cycle FIFO read strobe
//   rec_valid_out    out  record fields valid
//   rec_ready_in     in   downstream accepts record
//   cycle_number_out out  record cycle number
//   zero_offset_out  out  signed mean value
//   max_amp_out      out  signed max amplitude
//   max_time_out     out  index of the max sample
//   gap_out          out  this record's cycle number differs from the expected one
//   overflow_out     out  sticky: FIFO full seen
//   rec_count_out    out  records accepted downstream, wraps
module window_result_reader #(
  parameter int FIFO_STATE_SIZE   = 4,
  parameter int SAMPLE_DATA_SIZE  = 4,
  parameter int WINDOW_POW_SIZE   = 5,
  parameter int CYCLE_NUMBER_SIZE = 5,
  parameter int READ_LATENCY      = 2,
  parameter int COUNT_SIZE        = 16,
  localparam int OFS_SIZE         = SAMPLE_DATA_SIZE + $clog2(WINDOW_POW_SIZE),
  localparam int TIME_SIZE        = WINDOW_POW_SIZE - 1,
  localparam int READ_DATA_SIZE   = CYCLE_NUMBER_SIZE + OFS_SIZE + SAMPLE_DATA_SIZE + TIME_SIZE
) (
  input  logic                         clk,
  input  logic                         rst_in,
  input  logic                         enable_in,
  input  logic                         clear_in,
  input  logic [FIFO_STATE_SIZE-1:0]   fifo_state_in,
  input  logic [READ_DATA_SIZE-1:0]    read_data_in,
  output logic                         read_enable_out,
  output logic                         rec_valid_out,
  input  logic                         rec_ready_in,
  output logic [CYCLE_NUMBER_SIZE-1:0] cycle_number_out,
  output logic [OFS_SIZE-1:0]          zero_offset_out,
  output logic [SAMPLE_DATA_SIZE-1:0]  max_amp_out,
  output logic [TIME_SIZE-1:0]         max_time_out,
  output logic                         gap_out,
  output logic                         overflow_out,
  output logic [COUNT_SIZE-1:0]        rec_count_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  localparam int              LAT_W    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY - 1);

  state_t                       r_state;
  state_t                       w_next_state;
  logic [LAT_W-1:0]             r_wait_cnt;
  logic [READ_DATA_SIZE-1:0]    r_record;
  logic                         r_gap;
  logic                         r_overflow;
  logic                         r_have_prev;
  logic [CYCLE_NUMBER_SIZE-1:0] r_expected;
  logic [COUNT_SIZE-1:0]        r_rec_count;

  logic                         w_fifo_full;
  logic                         w_fifo_empty;
  logic                         w_wait_done;
  logic                         w_read_enable;
  logic                         w_rec_valid;
  logic                         w_handshake;
  logic                         w_hist_valid;
  logic [CYCLE_NUMBER_SIZE-1:0] w_cap_cycle;
  logic                         w_unused;

  assign w_fifo_full  = fifo_state_in[3];
  assign w_fifo_empty = fifo_state_in[2];
  // almost-full / almost-empty are not needed: one record in flight at most.
  assign w_unused     = ^fifo_state_in;

  assign w_cap_cycle  = read_data_in[READ_DATA_SIZE-1 -: CYCLE_NUMBER_SIZE];
  assign w_wait_done  = (r_state == ST_WAIT) && (r_wait_cnt == LAT_LAST);
  assign w_handshake  = w_rec_valid && rec_ready_in;
  // A clear in the capture cycle makes this record the first of a new history.
  assign w_hist_valid = r_have_prev && !clear_in;

  // State register
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic. Returning to IDLE after every record gives the FIFO empty
  // flag one cycle to reflect the read before the next decision.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (enable_in && !w_fifo_empty) w_next_state = ST_REQ;
      ST_REQ:  w_next_state = ST_WAIT;
      ST_WAIT: if (w_wait_done) w_next_state = ST_OUT;
      ST_OUT:  if (rec_ready_in) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    w_read_enable = 1'b0;
    w_rec_valid   = 1'b0;
    case (r_state)
      ST_REQ:  w_read_enable = 1'b1;
      ST_OUT:  w_rec_valid   = 1'b1;
      default: begin
        w_read_enable = 1'b0;
        w_rec_valid   = 1'b0;
      end
    endcase
  end

  // Read latency counter, restarted by every strobe
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      r_wait_cnt <= '0;
    end else if (r_state == ST_REQ) begin
      r_wait_cnt <= '0;
    end else if (r_state == ST_WAIT) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  // Record capture and gap history
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      r_record    <= '0;
      r_gap       <= 1'b0;
      r_have_prev <= 1'b0;
      r_expected  <= '0;
    end else if (w_wait_done) begin
      r_record    <= read_data_in;
      r_gap       <= w_hist_valid && (w_cap_cycle != r_expected);
      r_expected  <= w_cap_cycle + 1'b1;
      r_have_prev <= 1'b1;
    end else if (clear_in) begin
      r_have_prev <= 1'b0;
    end
  end

  // Accepted-record counter: clear beats a simultaneous handshake
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      r_rec_count <= '0;
    end else if (clear_in) begin
      r_rec_count <= '0;
    end else if (w_handshake) begin
      r_rec_count <= r_rec_count + 1'b1;
    end
  end

  // Sticky overflow: a full flag beats a simultaneous clear
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      r_overflow <= 1'b0;
    end else if (w_fifo_full) begin
      r_overflow <= 1'b1;
    end else if (clear_in) begin
      r_overflow <= 1'b0;
    end
  end

  assign read_enable_out  = w_read_enable;
  assign rec_valid_out    = w_rec_valid;
  assign cycle_number_out = r_record[READ_DATA_SIZE-1 -: CYCLE_NUMBER_SIZE];
  assign zero_offset_out  = r_record[READ_DATA_SIZE-CYCLE_NUMBER_SIZE-1 -: OFS_SIZE];
  assign max_amp_out      = r_record[SAMPLE_DATA_SIZE+TIME_SIZE-1 -: SAMPLE_DATA_SIZE];
  assign max_time_out     = r_record[TIME_SIZE-1:0];
  assign gap_out          = r_gap;
  assign overflow_out     = r_overflow;
  assign rec_count_out    = r_rec_count;

endmodule

// File: tb/tb_window_result_reader.sv
// tb/tb_window_result_reader.sv - self-checking bench for window_result_reader
module tb_window_result_reader;

  localparam int          LAT  = 2;
  localparam logic [19:0] JUNK = 20'hBAD00;

  typedef struct {
    logic [19:0] data;
    logic [4:0]  cyc;
    logic [6:0]  ofs;
    logic [3:0]  amp;
    logic [3:0]  tim;
    logic        gap;
  } rec_t;

  logic        clk          = 1'b0;
  logic        rst_in       = 1'b1;
  logic        enable_in    = 1'b0;
  logic        clear_in     = 1'b0;
  logic        rec_ready_in = 1'b0;
  logic [3:0]  fifo_state_in;
  logic [19:0] read_data_in = JUNK;
  logic        read_enable_out;
  logic        rec_valid_out;
  logic [4:0]  cycle_number_out;
  logic [6:0]  zero_offset_out;
  logic [3:0]  max_amp_out;
  logic [3:0]  max_time_out;
  logic        gap_out;
  logic        overflow_out;
  logic [15:0] rec_count_out;

  logic        tb_full  = 1'b0;
  logic        tb_empty = 1'b1;
  assign fifo_state_in = {tb_full, tb_empty, 1'b0, 1'b0};

  window_result_reader dut (
    .clk              (clk),
    .rst_in           (rst_in),
    .enable_in        (enable_in),
    .clear_in         (clear_in),
    .fifo_state_in    (fifo_state_in),
    .read_data_in     (read_data_in),
    .read_enable_out  (read_enable_out),
    .rec_valid_out    (rec_valid_out),
    .rec_ready_in     (rec_ready_in),
    .cycle_number_out (cycle_number_out),
    .zero_offset_out  (zero_offset_out),
    .max_amp_out      (max_amp_out),
    .max_time_out     (max_time_out),
    .gap_out          (gap_out),
    .overflow_out     (overflow_out),
    .rec_count_out    (rec_count_out)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  rec_t        vec [11];
  logic [19:0] fifo_q [$];
  rec_t        sb_q [$];
  logic [19:0] pipe [0:LAT];
  int          cyc = 0;
  int          prev_strobe = 0;
  int          strobes = 0;
  int          exp_count = 0;
  logic        have_prev = 1'b0;
  logic        chk_spacing = 1'b0;
  logic        cnt_pend = 1'b0;
  logic        prev_re = 1'b0;
  logic        prev_valid = 1'b0;
  rec_t        e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_rec(input int i);
    fifo_q.push_back(vec[i].data);
    sb_q.push_back(vec[i]);
  endtask

  task automatic wait_strobe(input int base, input string name);
    int n = 0;
    while (strobes == base && n < 50) begin
      tick(1);
      n++;
    end
    check(name, 32'(strobes > base), 32'd1);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!rec_valid_out && n < 50) begin
      tick(1);
      n++;
    end
    check(name, 32'(rec_valid_out), 32'd1);
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n = 0;
    while (sb_q.size() != 0 && n < limit) begin
      tick(1);
      n++;
    end
    check(name, 32'(sb_q.size()), 32'd0);
  endtask

  // Monitor, scoreboard consumer and FIFO model, all sampled on the falling edge.
  initial begin
    for (int i = 0; i <= LAT; i++) pipe[i] = JUNK;
    forever begin
      @(negedge clk);
      if (!rst_in) begin
        if (cnt_pend) check("rec_count", 32'(rec_count_out), 32'(exp_count));
        cnt_pend = 1'b0;
        if (read_enable_out) begin
          check("strobe_single", 32'(prev_re), 32'd0);
          check("strobe_not_empty", 32'(tb_empty), 32'd0);
          if (chk_spacing && have_prev) check("strobe_spacing", 32'(cyc - prev_strobe), 32'd5);
          prev_strobe = cyc;
          have_prev   = 1'b1;
          strobes++;
        end
        if (rec_valid_out && !prev_valid)
          check("valid_latency", 32'(cyc - prev_strobe), 32'(LAT + 1));
        if (rec_valid_out && rec_ready_in) begin
          if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_record: got cycle %0h expected no record", cycle_number_out);
          end else begin
            e = sb_q.pop_front();
            check("record_fields",
                  32'({cycle_number_out, zero_offset_out, max_amp_out, max_time_out, gap_out}),
                  32'({e.cyc, e.ofs, e.amp, e.tim, e.gap}));
          end
          exp_count++;
          cnt_pend = 1'b1;
        end
        if (clear_in) begin
          exp_count = 0;
          cnt_pend  = 1'b1;
        end
      end
      prev_re    = rst_in ? 1'b0 : read_enable_out;
      prev_valid = rst_in ? 1'b0 : rec_valid_out;
      cyc++;
      for (int i = LAT; i > 0; i--) pipe[i] = pipe[i-1];
      if (read_enable_out && fifo_q.size() > 0) pipe[0] = fifo_q.pop_front();
      else pipe[0] = JUNK;
      read_data_in = pipe[LAT];
      tb_empty     = (fifo_q.size() == 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int   s;
    logic stable;

    //        data       cyc    ofs    amp   time  gap
    vec[0]  = '{20'h1FE59, 5'd3,  7'h7E, 4'h5, 4'h9, 1'b0};
    vec[1]  = '{20'hF3F70, 5'd30, 7'h3F, 4'h7, 4'h0, 1'b0};
    vec[2]  = '{20'hFC08F, 5'd31, 7'h40, 4'h8, 4'hF, 1'b0};
    vec[3]  = '{20'h001F1, 5'd0,  7'h01, 4'hF, 4'h1, 1'b0};
    vec[4]  = '{20'h155A5, 5'd2,  7'h55, 4'hA, 4'h5, 1'b1};
    vec[5]  = '{20'h1AA5A, 5'd3,  7'h2A, 4'h5, 4'hA, 1'b0};
    vec[6]  = '{20'h21136, 5'd4,  7'h11, 4'h3, 4'h6, 1'b0};
    vec[7]  = '{20'h2FF82, 5'd5,  7'h7F, 4'h8, 4'h2, 1'b0};
    vec[8]  = '{20'h4807F, 5'd9,  7'h00, 4'h7, 4'hF, 1'b0};
    vec[9]  = '{20'h533C3, 5'd10, 7'h33, 4'hC, 4'h3, 1'b0};
    vec[10] = '{20'h5CC3C, 5'd11, 7'h4C, 4'h3, 4'hC, 1'b0};

    tick(3);
    rst_in = 1'b0;
    tick(1);
    check("reset_read_enable", 32'(read_enable_out), 32'd0);
    check("reset_valid", 32'(rec_valid_out), 32'd0);
    check("reset_fields", 32'({cycle_number_out, zero_offset_out, max_amp_out, max_time_out, gap_out}), 32'd0);
    check("reset_overflow", 32'(overflow_out), 32'd0);
    check("reset_count", 32'(rec_count_out), 32'd0);

    // Single record
    rec_ready_in = 1'b1;
    s = strobes;
    push_rec(0);
    enable_in = 1'b1;
    wait_drain("single_drain", 40);
    tick(2);
    check("single_strobes", 32'(strobes - s), 32'd1);
    check("single_count", 32'(rec_count_out), 32'd1);

    // Reset asserted in the middle of WAIT
    s = strobes;
    fifo_q.push_back(20'hABCDE);
    wait_strobe(s, "midreset_strobe");
    #2 rst_in = 1'b1;
    #1;
    check("midreset_read_enable", 32'(read_enable_out), 32'd0);
    check("midreset_valid", 32'(rec_valid_out), 32'd0);
    check("midreset_fields", 32'({cycle_number_out, zero_offset_out, max_amp_out, max_time_out, gap_out}), 32'd0);
    check("midreset_count", 32'(rec_count_out), 32'd0);
    fifo_q.delete();
    sb_q.delete();
    exp_count = 0;
    cnt_pend  = 1'b0;
    enable_in = 1'b0;
    tick(3);
    rst_in = 1'b0;
    s = strobes;
    tick(5);
    check("midreset_idle_valid", 32'(rec_valid_out), 32'd0);
    check("midreset_idle_reads", 32'(strobes - s), 32'd0);

    // Burst of five records: wrap 31->0 is not a gap, 0->2 is; spacing fixed
    enable_in = 1'b1;
    clear_in  = 1'b1;
    tick(1);
    clear_in    = 1'b0;
    have_prev   = 1'b0;
    chk_spacing = 1'b1;
    s = strobes;
    for (int i = 1; i <= 5; i++) push_rec(i);
    wait_drain("burst_drain", 200);
    tick(30);
    chk_spacing = 1'b0;
    check("burst_strobes", 32'(strobes - s), 32'd5);
    check("burst_count", 32'(rec_count_out), 32'd5);

    // Back-pressure: ready low for 20 cycles with another record waiting
    rec_ready_in = 1'b0;
    push_rec(6);
    wait_valid("hold_valid");
    push_rec(7);
    s = strobes;
    stable = 1'b1;
    repeat (20) begin
      tick(1);
      if (!rec_valid_out ||
          {cycle_number_out, zero_offset_out, max_amp_out, max_time_out, gap_out} !==
          {vec[6].cyc, vec[6].ofs, vec[6].amp, vec[6].tim, vec[6].gap})
        stable = 1'b0;
    end
    check("hold_stable", 32'(stable), 32'd1);
    check("hold_no_extra_read", 32'(strobes - s), 32'd0);
    check("hold_count", 32'(rec_count_out), 32'd5);
    rec_ready_in = 1'b1;
    tick(1);
    rec_ready_in = 1'b0;
    check("hold_count_after", 32'(rec_count_out), 32'd6);

    // Clear together with a handshake: clear wins, gap history restarts
    wait_valid("clrhs_valid");
    rec_ready_in = 1'b1;
    clear_in     = 1'b1;
    tick(1);
    clear_in = 1'b0;
    check("clrhs_count", 32'(rec_count_out), 32'd0);
    push_rec(8);
    wait_drain("clrhs_drain", 40);

    // enable_in dropped mid-record: record completes, no further read
    s = strobes;
    push_rec(9);
    push_rec(10);
    wait_strobe(s, "enoff_strobe");
    enable_in = 1'b0;
    tick(15);
    check("enoff_reads", 32'(strobes - s), 32'd1);
    check("enoff_pending", 32'(sb_q.size()), 32'd1);
    enable_in = 1'b1;
    wait_drain("enoff_drain", 40);
    tick(1);
    check("enoff_count", 32'(rec_count_out), 32'd3);

    // Empty FIFO: no reads; overflow set/sticky/clear behaviour
    s = strobes;
    tick(50);
    check("empty_no_read", 32'(strobes - s), 32'd0);
    check("ovf_initial", 32'(overflow_out), 32'd0);
    tb_full = 1'b1;
    tick(1);
    tb_full = 1'b0;
    check("ovf_set", 32'(overflow_out), 32'd1);
    tick(10);
    check("ovf_sticky", 32'(overflow_out), 32'd1);
    clear_in = 1'b1;
    tick(1);
    clear_in = 1'b0;
    check("ovf_cleared", 32'(overflow_out), 32'd0);
    clear_in = 1'b1;
    tb_full  = 1'b1;
    tick(1);
    clear_in = 1'b0;
    tb_full  = 1'b0;
    check("ovf_set_wins", 32'(overflow_out), 32'd1);
    clear_in = 1'b1;
    tick(1);
    clear_in = 1'b0;
    check("ovf_cleared_again", 32'(overflow_out), 32'd0);

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
